// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port plus the fetch/decode handshake
// and the redirect inputs coming back from decode.
interface fetch_if;
    logic [31:0] program_counter;
    logic [31:0] instruction;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic        done;

    modport master (
        output program_counter, if_valid, if_instr, if_pc, done,
        input  instruction, id_ready, branch_taken, branch_offset, jump, jump_target
    );

    modport slave (
        input  program_counter, if_valid, if_instr, if_pc, done,
        output instruction, id_ready, branch_taken, branch_offset, jump, jump_target
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: word-indexed PC, one-entry fetch register with valid/ready, redirects.
// Define FETCH_STALL_CNT_EN to add a saturating stall_count output.
module fetch_unit #(
    parameter int unsigned IMEM_DEPTH = 3,
    parameter int unsigned RESET_PC   = 0
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef FETCH_STALL_CNT_EN
    output logic [15:0] stall_count,
`endif
    fetch_if.master     bus
);
    localparam logic [31:0] RstPc   = 32'(RESET_PC);
    localparam logic        RstDone = (RESET_PC >= IMEM_DEPTH);

    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] ipc_q, ipc_d;
    logic        valid_q, valid_d;
    logic        done_q, done_d;

    logic        fire, redir;
    logic [31:0] target, pc_inc;

    assign fire   = valid_q && bus.id_ready;
    assign redir  = valid_q && (bus.jump || bus.branch_taken);
    assign pc_inc = pc_q + 32'd1;

    always_comb begin
        target = ipc_q + 32'd1 + {{16{bus.branch_offset[15]}}, bus.branch_offset};
        if (bus.jump) begin
            target = {ipc_q[31:26], bus.jump_target};
        end
    end

    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        done_d  = done_q;
        if (redir) begin
            // Flush the wrong-path entry regardless of id_ready
            pc_d    = target;
            valid_d = 1'b0;
            done_d  = (target >= IMEM_DEPTH);
        end else if (valid_q && !bus.id_ready) begin
            // Stall: hold everything
        end else if (!done_q) begin
            instr_d = bus.instruction;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_inc;
            done_d  = (pc_inc >= IMEM_DEPTH);
        end else if (fire) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RstPc;
            instr_q <= '0;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= RstDone;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (valid_q && !bus.id_ready && !redir && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

    assign bus.program_counter = pc_q;
    assign bus.if_valid        = valid_q;
    assign bus.if_instr        = instr_q;
    assign bus.if_pc           = ipc_q;
    assign bus.done            = done_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a three-word instruction memory model.
module tb_fetch_unit;
    localparam logic [31:0] InstrA = 32'hA000_0001;
    localparam logic [31:0] InstrB = 32'hB000_0002;
    localparam logic [31:0] InstrC = 32'hC000_0003;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    fetch_if bus_if ();

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    fetch_unit #(
        .IMEM_DEPTH (3),
        .RESET_PC   (0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
`ifdef FETCH_STALL_CNT_EN
        .stall_count (stall_count),
`endif
        .bus         (bus_if.master)
    );

    always_comb begin
        case (bus_if.program_counter)
            32'd0:   bus_if.instruction = InstrA;
            32'd1:   bus_if.instruction = InstrB;
            32'd2:   bus_if.instruction = InstrC;
            default: bus_if.instruction = 32'hDEAD_BEEF;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_redirect();
        bus_if.branch_taken  = 1'b0;
        bus_if.branch_offset = 16'h0000;
        bus_if.jump          = 1'b0;
        bus_if.jump_target   = 26'd0;
    endtask

    // Reset held across one edge, released 1 time unit after it.
    task automatic do_reset();
        rst_n            = 1'b0;
        bus_if.id_ready  = 1'b0;
        clear_redirect();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        bus_if.id_ready = 1'b0;
        clear_redirect();
        #2;
        check("rst_pc", bus_if.program_counter, 32'd0);
        check("rst_valid", 32'(bus_if.if_valid), 32'd0);
        check("rst_instr", bus_if.if_instr, 32'd0);
        check("rst_ifpc", bus_if.if_pc, 32'd0);
        check("rst_done", 32'(bus_if.done), 32'd0);

        // Straight-line fetch A,B,C then drain
        do_reset();
        bus_if.id_ready = 1'b1;
        tick();
        check("seq0_valid", 32'(bus_if.if_valid), 32'd1);
        check("seq0_pc", bus_if.if_pc, 32'd0);
        check("seq0_instr", bus_if.if_instr, InstrA);
        tick();
        check("seq1_pc", bus_if.if_pc, 32'd1);
        check("seq1_instr", bus_if.if_instr, InstrB);
        tick();
        check("seq2_pc", bus_if.if_pc, 32'd2);
        check("seq2_instr", bus_if.if_instr, InstrC);
        check("seq2_prog", bus_if.program_counter, 32'd3);
        check("seq2_done", 32'(bus_if.done), 32'd1);
        tick();
        check("drain_valid", 32'(bus_if.if_valid), 32'd0);
        check("drain_done", 32'(bus_if.done), 32'd1);
        tick();
        check("idle_prog", bus_if.program_counter, 32'd3);

        // Stall for 3 cycles at if_pc=1
        do_reset();
        bus_if.id_ready = 1'b1;
        tick();
        tick();
        bus_if.id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_instr", bus_if.if_instr, InstrB);
            check("stall_prog", bus_if.program_counter, 32'd2);
            check("stall_valid", 32'(bus_if.if_valid), 32'd1);
        end
`ifdef FETCH_STALL_CNT_EN
        check("stall_count", 32'(stall_count), 32'd3);
`endif
        bus_if.id_ready = 1'b1;
        tick();
        check("resume_pc", bus_if.if_pc, 32'd2);
        check("resume_instr", bus_if.if_instr, InstrC);

        // Backward branch at if_pc=1 refetches itself
        do_reset();
        bus_if.id_ready = 1'b1;
        tick();
        tick();
        bus_if.branch_taken  = 1'b1;
        bus_if.branch_offset = 16'hFFFF;
        tick();
        clear_redirect();
        check("br_prog", bus_if.program_counter, 32'd1);
        check("br_valid", 32'(bus_if.if_valid), 32'd0);
        tick();
        check("br_refetch_pc", bus_if.if_pc, 32'd1);
        check("br_refetch_instr", bus_if.if_instr, InstrB);

        // Jump beats branch, issued as done goes high; clears done
        tick();
        check("pre_jump_done", 32'(bus_if.done), 32'd1);
        bus_if.jump          = 1'b1;
        bus_if.jump_target   = 26'd0;
        bus_if.branch_taken  = 1'b1;
        bus_if.branch_offset = 16'd5;
        tick();
        clear_redirect();
        check("jump_prog", bus_if.program_counter, 32'd0);
        check("jump_done", 32'(bus_if.done), 32'd0);
        check("jump_valid", 32'(bus_if.if_valid), 32'd0);
        tick();
        check("jump_refetch_instr", bus_if.if_instr, InstrA);

        // Redirect while if_valid=0 is ignored; then branch out of range
        do_reset();
        bus_if.id_ready    = 1'b1;
        bus_if.jump        = 1'b1;
        bus_if.jump_target = 26'd2;
        tick();
        check("ign_prog", bus_if.program_counter, 32'd1);
        check("ign_pc", bus_if.if_pc, 32'd0);
        clear_redirect();
        bus_if.branch_taken  = 1'b1;
        bus_if.branch_offset = 16'd5;
        tick();
        clear_redirect();
        check("far_prog", bus_if.program_counter, 32'd6);
        check("far_done", 32'(bus_if.done), 32'd1);
        check("far_valid", 32'(bus_if.if_valid), 32'd0);
        tick();
        check("far_nocap", 32'(bus_if.if_valid), 32'd0);
        check("far_hold", bus_if.program_counter, 32'd6);

        // Asynchronous reset in the middle of a stall
        do_reset();
        bus_if.id_ready = 1'b1;
        tick();
        bus_if.id_ready = 1'b0;
        tick();
        check("mid_valid_pre", 32'(bus_if.if_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(bus_if.if_valid), 32'd0);
        check("async_prog", bus_if.program_counter, 32'd0);
        check("async_ifpc", bus_if.if_pc, 32'd0);
        rst_n = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
